// File: rtl/l2_port_arbiter_if.sv
// Bus bundle between the two L1 miss-fetch FSMs, the L2 port arbiter and
// the single-ported L2. Port 0 is the I-cache, port 1 is the D-cache.
// The arbiter connects through the slave modport; the environment (caches
// plus L2) connects through the master modport.
interface l2_port_arbiter_if #(
   parameter int unsigned BLOCKS = 4
);
   localparam int unsigned BW = BLOCKS * 32;

   // cache port 0 (I-cache)
   logic          p0_req;
   logic          p0_we;
   logic [31:0]   p0_addr;
   logic [BW-1:0] p0_write_block;
   logic [BW-1:0] p0_read_block;
   logic          p0_miss;

   // cache port 1 (D-cache)
   logic          p1_req;
   logic          p1_we;
   logic [31:0]   p1_addr;
   logic [BW-1:0] p1_write_block;
   logic [BW-1:0] p1_read_block;
   logic          p1_miss;

   // shared L2 side
   logic          l2_req;
   logic          l2_we;
   logic [31:0]   l2_addr;
   logic [BW-1:0] l2_write_block;
   logic [BW-1:0] l2_read_block;
   logic          l2_miss;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_write_block,
      output p0_read_block, p0_miss,
      input  p1_req, p1_we, p1_addr, p1_write_block,
      output p1_read_block, p1_miss,
      output l2_req, l2_we, l2_addr, l2_write_block,
      input  l2_read_block, l2_miss
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_write_block,
      input  p0_read_block, p0_miss,
      output p1_req, p1_we, p1_addr, p1_write_block,
      input  p1_read_block, p1_miss,
      input  l2_req, l2_we, l2_addr, l2_write_block,
      output l2_read_block, l2_miss
   );
endinterface

// File: rtl/l2_port_arbiter.sv
// Two-port arbiter for the single-ported L2. One cache port owns the L2
// for its whole miss sequence (optional write-back, then fill); ownership
// ends when that port drops its request. Grants are registered, so going
// from IDLE to a grant costs one cycle; a release with the other port
// waiting hands over directly without passing through IDLE.
// Optional macro L2_ARB_ROUND_ROBIN_EN: tie between the ports goes to the
// port not granted last. Without it, port 1 (D-cache) wins every tie.
// Per-port saturating counters report cycles spent requesting without
// holding the grant.
module l2_port_arbiter #(
   parameter int unsigned BLOCKS = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clock,
   input  logic             reset,
   l2_port_arbiter_if.slave bus,
   output logic [CNT_W-1:0] p0_wait_cnt,
   output logic [CNT_W-1:0] p1_wait_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   tie_to_p1;

`ifdef L2_ARB_ROUND_ROBIN_EN
   logic last_gnt;
   logic last_gnt_nxt;

   // Pointer tracks which port received the most recent new grant.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_gnt <= 1'b0;
      end else begin
         last_gnt <= last_gnt_nxt;
      end
   end

   // Every entry into a grant state (from IDLE or by handoff) moves the pointer.
   always_comb begin
      last_gnt_nxt = last_gnt;
      if (state_nxt != state && state_nxt != IDLE) begin
         last_gnt_nxt = (state_nxt == GNT1);
      end
   end

   // A tie goes to the port that was not granted last.
   always_comb begin
      tie_to_p1 = ~last_gnt;
   end
`else
   // Fixed priority: the D-cache wins every tie.
   always_comb begin
      tie_to_p1 = 1'b1;
   end
`endif

   // Grant state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next grant: arbitrate in IDLE, hold while the owner requests, hand off on release.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.p0_req && bus.p1_req) begin
               state_nxt = tie_to_p1 ? GNT1 : GNT0;
            end else if (bus.p1_req) begin
               state_nxt = GNT1;
            end else if (bus.p0_req) begin
               state_nxt = GNT0;
            end
         end
         GNT0: begin
            if (!bus.p0_req) begin
               state_nxt = bus.p1_req ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!bus.p1_req) begin
               state_nxt = bus.p0_req ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Steer the owning port onto the L2 and return L2 status/data to it only.
   // l2_req follows the owner's req, so it is already low in the release cycle.
   always_comb begin
      bus.l2_req         = 1'b0;
      bus.l2_we          = 1'b0;
      bus.l2_addr        = '0;
      bus.l2_write_block = '0;
      bus.p0_miss        = bus.p0_req;
      bus.p1_miss        = bus.p1_req;
      bus.p0_read_block  = '0;
      bus.p1_read_block  = '0;
      unique case (state)
         GNT0: begin
            bus.l2_req         = bus.p0_req;
            bus.l2_we          = bus.p0_we;
            bus.l2_addr        = bus.p0_addr;
            bus.l2_write_block = bus.p0_write_block;
            bus.p0_miss        = bus.l2_miss;
            bus.p0_read_block  = bus.l2_read_block;
            bus.p1_miss        = 1'b1;
         end
         GNT1: begin
            bus.l2_req         = bus.p1_req;
            bus.l2_we          = bus.p1_we;
            bus.l2_addr        = bus.p1_addr;
            bus.l2_write_block = bus.p1_write_block;
            bus.p1_miss        = bus.l2_miss;
            bus.p1_read_block  = bus.l2_read_block;
            bus.p0_miss        = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Port 0 wait counter: counts requesting-but-not-granted cycles, sticks at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p0_wait_cnt <= '0;
      end else if (bus.p0_req && state != GNT0 && p0_wait_cnt != '1) begin
         p0_wait_cnt <= p0_wait_cnt + CNT_W'(1);
      end
   end

   // Port 1 wait counter: counts requesting-but-not-granted cycles, sticks at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p1_wait_cnt <= '0;
      end else if (bus.p1_req && state != GNT1 && p1_wait_cnt != '1) begin
         p1_wait_cnt <= p1_wait_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter. The stimulus process drives the
// ports and the L2 after each rising edge, advances a behavioural owner
// model and queues the expected outputs; a monitor pops and compares on
// each falling edge. A second instance with 4-bit counters covers
// counter saturation.
module tb_l2_port_arbiter;

   localparam int unsigned BLOCKS = 4;
   localparam int unsigned BW     = BLOCKS * 32;
   localparam int unsigned CNT_W  = 32;
   localparam longint      CMAX   = (64'd1 << CNT_W) - 1;

`ifdef L2_ARB_ROUND_ROBIN_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic clock;
   logic reset;
   logic [CNT_W-1:0] p0_wait_cnt, p1_wait_cnt;
   logic [3:0]       s_p0_wait_cnt, s_p1_wait_cnt;

   l2_port_arbiter_if #(.BLOCKS(BLOCKS)) bus ();
   l2_port_arbiter_if #(.BLOCKS(BLOCKS)) bus_s ();

   l2_port_arbiter #(.BLOCKS(BLOCKS), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.slave),
      .p0_wait_cnt (p0_wait_cnt),
      .p1_wait_cnt (p1_wait_cnt)
   );

   l2_port_arbiter #(.BLOCKS(BLOCKS), .CNT_W(4)) dut_sat (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus_s.slave),
      .p0_wait_cnt (s_p0_wait_cnt),
      .p1_wait_cnt (s_p1_wait_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct packed {
      logic          l2_req;
      logic          l2_we;
      logic [31:0]   l2_addr;
      logic [BW-1:0] l2_wb;
      logic          m0;
      logic          m1;
      logic [BW-1:0] rb0;
      logic [BW-1:0] rb1;
      logic [31:0]   c0;
      logic [31:0]   c1;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // stimulus values (what the environment drives)
   logic          req[2];
   logic          we[2];
   logic [31:0]   addr[2];
   logic [BW-1:0] wb[2];
   logic          l2_miss;
   logic [BW-1:0] l2_rblk;
   logic          done_prev[2];

   // reference model: who owns the L2 (-1 none), last granted port, wait counts
   int     owner;
   int     last;
   longint cnt[2];

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      owner  = -1;
      last   = 0;
      cnt[0] = 0;
      cnt[1] = 0;
   endtask

   // One clock edge of the reference: counters, then ownership change.
   task automatic model_edge();
      int prev;
      prev = owner;
      for (int k = 0; k < 2; k++) begin
         if (req[k] && prev != k && cnt[k] < CMAX) cnt[k]++;
      end
      if (prev < 0) begin
         if (req[0] && req[1]) owner = RR_MODE ? (1 - last) : 1;
         else if (req[1])      owner = 1;
         else if (req[0])      owner = 0;
         if (owner >= 0) last = owner;
      end else if (!req[prev]) begin
         if (req[1 - prev]) begin
            owner = 1 - prev;
            last  = owner;
         end else begin
            owner = -1;
         end
      end
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
      if (reset) model_edge();
   endtask

   // Drive current stimulus and queue the outputs the model expects this cycle.
   task automatic drive();
      exp_t e;
      bus.p0_req = req[0];  bus.p0_we = we[0];  bus.p0_addr = addr[0];  bus.p0_write_block = wb[0];
      bus.p1_req = req[1];  bus.p1_we = we[1];  bus.p1_addr = addr[1];  bus.p1_write_block = wb[1];
      bus.l2_miss = l2_miss;
      bus.l2_read_block = l2_rblk;
      e = '0;
      if (owner < 0) begin
         e.m0 = req[0];
         e.m1 = req[1];
      end else begin
         e.l2_req = req[owner];
         e.l2_we  = we[owner];
         e.l2_addr = addr[owner];
         e.l2_wb  = wb[owner];
         if (owner == 0) begin
            e.m0 = l2_miss; e.rb0 = l2_rblk; e.m1 = 1'b1;
         end else begin
            e.m1 = l2_miss; e.rb1 = l2_rblk; e.m0 = 1'b1;
         end
      end
      e.c0 = cnt[0][31:0];
      e.c1 = cnt[1][31:0];
      for (int k = 0; k < 2; k++) done_prev[k] = req[k] && (owner == k) && !l2_miss;
      exp_q.push_back(e);
   endtask

   task automatic set_port(input int k, input logic r, input logic w, input logic [31:0] a);
      req[k]  = r;
      we[k]   = w;
      addr[k] = a;
      wb[k]   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // monitor: compare the DUT against the oldest queued expectation
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("l2_req",         BW'(bus.l2_req),        BW'(e.l2_req));
            chk("l2_we",          BW'(bus.l2_we),         BW'(e.l2_we));
            chk("l2_addr",        BW'(bus.l2_addr),       BW'(e.l2_addr));
            chk("l2_write_block", bus.l2_write_block,     e.l2_wb);
            chk("p0_miss",        BW'(bus.p0_miss),       BW'(e.m0));
            chk("p1_miss",        BW'(bus.p1_miss),       BW'(e.m1));
            chk("p0_read_block",  bus.p0_read_block,      e.rb0);
            chk("p1_read_block",  bus.p1_read_block,      e.rb1);
            chk("p0_wait_cnt",    BW'(p0_wait_cnt),       BW'(e.c0));
            chk("p1_wait_cnt",    BW'(p1_wait_cnt),       BW'(e.c1));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // reset with everything idle
      for (int k = 0; k < 2; k++) set_port(k, 1'b0, 1'b0, 32'h0);
      l2_miss = 1'b1;
      l2_rblk = '0;
      reset   = 1'b0;
      model_reset();
      bus_s.p0_req = 1'b0; bus_s.p0_we = 1'b0; bus_s.p0_addr = '0; bus_s.p0_write_block = '0;
      bus_s.p1_req = 1'b0; bus_s.p1_we = 1'b0; bus_s.p1_addr = '0; bus_s.p1_write_block = '0;
      bus_s.l2_miss = 1'b1; bus_s.l2_read_block = '0;
      repeat (2) begin advance(); drive(); end
      advance(); reset = 1'b1; drive();

      // single fill by port 0: 1 arbitration cycle, 3 stall cycles, done
      advance(); set_port(0, 1'b1, 1'b0, 32'h100); l2_miss = 1'b1; drive();
      repeat (3) begin advance(); drive(); end
      advance(); l2_miss = 1'b0; l2_rblk = {32'd1, 32'd2, 32'd3, 32'd4}; drive();
      advance(); req[0] = 1'b0; l2_miss = 1'b1; drive();
      advance(); drive();

      // port 1 write-back then fill, port 0 waiting, then handoff to port 0
      advance(); set_port(1, 1'b1, 1'b1, 32'h2000); drive();
      advance(); set_port(0, 1'b1, 1'b0, 32'h440); drive();
      advance(); drive();
      advance(); l2_miss = 1'b0; drive();
      advance(); set_port(1, 1'b1, 1'b0, 32'h3000); l2_miss = 1'b1; drive();
      advance(); drive();
      advance(); l2_miss = 1'b0; l2_rblk = {4{32'hCAFE_0001}}; drive();
      advance(); req[1] = 1'b0; l2_miss = 1'b1; drive();
      advance(); drive();
      advance(); l2_miss = 1'b0; drive();
      advance(); req[0] = 1'b0; l2_miss = 1'b1; drive();
      advance(); drive();

      // three ties from IDLE
      repeat (3) begin
         advance(); set_port(0, 1'b1, 1'b0, 32'h500); set_port(1, 1'b1, 1'b0, 32'h600); drive();
         advance(); l2_miss = 1'b0; drive();
         advance(); req[0] = 1'b0; req[1] = 1'b0; l2_miss = 1'b1; drive();
         advance(); drive();
      end

      // reset in the middle of a port 0 access with port 1 pending
      advance(); set_port(0, 1'b1, 1'b0, 32'h700); drive();
      advance(); set_port(1, 1'b1, 1'b0, 32'h800); drive();
      advance(); drive();
      advance(); reset = 1'b0; req[0] = 1'b0; model_reset(); drive();
      advance(); drive();
      advance(); reset = 1'b1; drive();
      advance(); drive();
      advance(); l2_miss = 1'b0; drive();
      advance(); req[1] = 1'b0; l2_miss = 1'b1; drive();

      // randomized traffic
      repeat (3000) begin
         advance();
         for (int k = 0; k < 2; k++) begin
            if (!req[k]) begin
               if ($urandom_range(2) == 0) set_port(k, 1'b1, 1'($urandom_range(1)), $urandom);
            end else if (done_prev[k]) begin
               if ($urandom_range(1) == 0) req[k] = 1'b0;
               else set_port(k, 1'b1, 1'b0, $urandom);
            end else if ($urandom_range(60) == 0) begin
               req[k] = 1'b0;
            end
         end
         l2_miss = ($urandom_range(2) != 0);
         l2_rblk = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(400) == 0) begin
            reset = 1'b0;
            model_reset();
         end else if (!reset) begin
            reset = 1'b1;
         end
         drive();
      end
      advance(); reset = 1'b1; drive();
      @(negedge clock);
      #1;
      chk("queue_drained", BW'(exp_q.size()), BW'(0));

      // saturation on the 4-bit instance: port 0 owns, port 1 waits 20 cycles
      @(posedge clock); #1; bus_s.p0_req = 1'b1;
      @(posedge clock); #1; bus_s.p1_req = 1'b1;
      repeat (10) begin @(posedge clock); #1; end
      @(negedge clock);
      chk("sat_p1_cnt_10", BW'(s_p1_wait_cnt), BW'(10));
      chk("sat_p0_cnt",    BW'(s_p0_wait_cnt), BW'(1));
      chk("sat_p1_miss",   BW'(bus_s.p1_miss), BW'(1));
      repeat (10) begin @(posedge clock); #1; end
      @(negedge clock);
      chk("sat_p1_cnt_20", BW'(s_p1_wait_cnt), BW'(15));
      repeat (5) begin @(posedge clock); #1; end
      @(negedge clock);
      chk("sat_p1_cnt_hold", BW'(s_p1_wait_cnt), BW'(15));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
